// File: rtl/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: shares one simulation-memory request port between
// NumReq in-order requesters. Round-robin arbitration with request locking
// while the memory withholds its grant; responses are routed back in order
// through an ID FIFO.
// Optional feature: define TB_MEM_ARB_PERF_EN to add perf_stall_o, a
// per-requester saturating count of stalled request cycles.
module tb_mem_port_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            mem_req_o,
    input  logic                            mem_gnt_i,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic                            mem_we_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_strb_o,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i
`ifdef TB_MEM_ARB_PERF_EN
    ,
    output logic [NumReq*32-1:0]            perf_stall_o
`endif
);

    localparam int unsigned IdW   = $clog2(NumReq);
    localparam int unsigned PtrW  = $clog2(MaxOutstanding);
    localparam int unsigned StrbW = DataWidth / 8;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IdW-1:0]    r_rr;
    logic [IdW-1:0]    r_sel_lock;
    logic [IdW-1:0]    w_rr_sel;
    logic [IdW-1:0]    w_sel;
    int unsigned       w_sel_int;
    logic              w_found;
    logic              w_full;
    logic              w_empty;
    logic              w_xfer;
    logic              w_pop;
    logic [IdW-1:0]    r_fifo [MaxOutstanding];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_cnt;

    // Round-robin search: first valid requester at or after the rr pointer
    always_comb begin
        w_rr_sel = r_rr;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            int unsigned idx;
            idx = (32'(r_rr) + k) % NumReq;
            if (!w_found && req_valid_i[idx]) begin
                w_rr_sel = IdW'(idx);
                w_found  = 1'b1;
            end
        end
    end

    assign w_sel     = (r_state == ST_LOCKED) ? r_sel_lock : w_rr_sel;
    assign w_sel_int = 32'(w_sel);
    assign w_full    = (r_cnt == (PtrW+1)'(MaxOutstanding));
    assign w_empty   = (r_cnt == '0);

    // Request is gated by reset so the port is quiet the instant reset asserts
    assign mem_req_o   = rst_ni & (|req_valid_i) & ~w_full;
    assign w_xfer      = mem_req_o & mem_gnt_i;
    assign w_pop       = mem_rvalid_i & ~w_empty;

    assign mem_addr_o  = req_addr_i[w_sel_int*AddrWidth +: AddrWidth];
    assign mem_we_o    = req_we_i[w_sel_int];
    assign mem_wdata_o = req_wdata_i[w_sel_int*DataWidth +: DataWidth];
    assign mem_strb_o  = req_strb_i[w_sel_int*StrbW +: StrbW];
    assign rsp_rdata_o = mem_rdata_i;

    // Ready only to the selected requester, in the cycle memory grants
    always_comb begin
        req_ready_o = '0;
        if (w_xfer) begin
            req_ready_o[w_sel] = 1'b1;
        end
    end

    // Response strobe goes to whichever requester sits at the FIFO head
    always_comb begin
        rsp_valid_o = '0;
        if (w_pop) begin
            rsp_valid_o[r_fifo[r_rd_ptr]] = 1'b1;
        end
    end

    // Lock FSM next state: lock on an ungranted request, release on transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OPEN:   if (mem_req_o && !mem_gnt_i) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_xfer)                  w_state_nxt = ST_OPEN;
            default:   w_state_nxt = ST_OPEN;
        endcase
    end

    // Lock state, held selection and rr pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_OPEN;
            r_sel_lock <= '0;
            r_rr       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_OPEN && mem_req_o && !mem_gnt_i) begin
                r_sel_lock <= w_rr_sel;
            end
            if (w_xfer) begin
                r_rr <= (w_sel == IdW'(NumReq - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    // ID FIFO: push granted requester, pop on each memory response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef TB_MEM_ARB_PERF_EN
    logic [31:0] r_stall [NumReq];

    // Saturating per-requester stall counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                r_stall[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (req_valid_i[i] && !req_ready_o[i] && r_stall[i] != '1) begin
                    r_stall[i] <= r_stall[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_perf
        assign perf_stall_o[g*32 +: 32] = r_stall[g];
    end
`endif

    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_LOCKED) |-> req_valid_i[r_sel_lock]);

    a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !w_empty);

endmodule

// File: tb/tb_tb_mem_port_arbiter.sv
// Directed bench for tb_mem_port_arbiter: a per-cycle vector table covering
// single transfer, alternating round-robin and lock hold, followed by
// hand-written sequences for FIFO-full blocking, async reset and the
// optional stall counters (TB_MEM_ARB_PERF_EN).
module tb_tb_mem_port_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR-1:0]     req_we_i;
    logic [NR*DW-1:0]  req_wdata_i;
    logic [NR*DW/8-1:0] req_strb_i;
    logic [NR-1:0]     rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [AW-1:0]     mem_addr_o;
    logic              mem_we_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW/8-1:0]   mem_strb_o;
    logic              mem_rvalid_i;
    logic [DW-1:0]     mem_rdata_i;
`ifdef TB_MEM_ARB_PERF_EN
    logic [NR*32-1:0]  perf_stall_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign req_addr_i  = {48'h2000, 48'h1000};
    assign req_we_i    = 2'b10;
    assign req_wdata_i = {64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    assign req_strb_i  = {8'h0F, 8'hFF};

    tb_mem_port_arbiter #(
        .NumReq(NR),
        .AddrWidth(AW),
        .DataWidth(DW),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i),
        .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i),
        .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_strb_o(mem_strb_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
`ifdef TB_MEM_ARB_PERF_EN
        ,
        .perf_stall_o(perf_stall_o)
`endif
    );

    typedef struct {
        logic [1:0]  v;
        logic        g;
        logic        rv;
        logic [7:0]  rd;
        logic [1:0]  rdy;
        logic        mreq;
        logic [1:0]  rsp;
        logic [47:0] addr;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic g, input logic rv, input logic [7:0] rd);
        req_valid_i  = v;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = {8{rd}};
    endtask

    initial begin
        // per-cycle vectors: valid, gnt, rvalid, rdata byte | ready, mem_req, rsp_valid, mem_addr
        vt[0]  = '{2'b01, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 2'b00, 48'h1000};
        vt[1]  = '{2'b00, 1'b0, 1'b1, 8'hAA, 2'b00, 1'b0, 2'b01, 48'h0};
        vt[2]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 2'b00, 48'h2000};
        vt[3]  = '{2'b11, 1'b1, 1'b1, 8'h11, 2'b01, 1'b1, 2'b10, 48'h1000};
        vt[4]  = '{2'b11, 1'b1, 1'b1, 8'h22, 2'b10, 1'b1, 2'b01, 48'h2000};
        vt[5]  = '{2'b11, 1'b1, 1'b1, 8'h33, 2'b01, 1'b1, 2'b10, 48'h1000};
        vt[6]  = '{2'b00, 1'b0, 1'b1, 8'h44, 2'b00, 1'b0, 2'b01, 48'h0};
        vt[7]  = '{2'b10, 1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 2'b00, 48'h2000};
        vt[8]  = '{2'b00, 1'b0, 1'b1, 8'h55, 2'b00, 1'b0, 2'b10, 48'h0};
        vt[9]  = '{2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 2'b00, 48'h2000};
        vt[10] = '{2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 2'b00, 48'h2000};
        vt[11] = '{2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 2'b00, 48'h2000};
        vt[12] = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 2'b00, 48'h2000};
        vt[13] = '{2'b01, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 2'b00, 48'h1000};
        vt[14] = '{2'b00, 1'b0, 1'b1, 8'h66, 2'b00, 1'b0, 2'b10, 48'h0};
        vt[15] = '{2'b00, 1'b0, 1'b1, 8'h77, 2'b00, 1'b0, 2'b01, 48'h0};

        // reset state, with requests pending to show they are masked
        rst_ni = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 8'h00);
        #2;
        chk("reset mem_req", 64'(mem_req_o), 64'h0);
        chk("reset ready", 64'(req_ready_o), 64'h0);
        chk("reset rsp_valid", 64'(rsp_valid_o), 64'h0);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i].v, vt[i].g, vt[i].rv, vt[i].rd);
            #1;
            chk($sformatf("v%0d ready", i), 64'(req_ready_o), 64'(vt[i].rdy));
            chk($sformatf("v%0d mem_req", i), 64'(mem_req_o), 64'(vt[i].mreq));
            chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid_o), 64'(vt[i].rsp));
            if (vt[i].mreq) begin
                chk($sformatf("v%0d mem_addr", i), 64'(mem_addr_o), 64'(vt[i].addr));
                chk($sformatf("v%0d mem_we", i), 64'(mem_we_o), 64'(vt[i].addr == 48'h2000));
            end
            if (vt[i].rsp != 2'b00) begin
                chk($sformatf("v%0d rdata", i), rsp_rdata_o, {8{vt[i].rd}});
            end
        end

        // fill to MaxOutstanding, then the next request is blocked
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(2'b01, 1'b1, 1'b0, 8'h00);
            #1;
            chk($sformatf("fill%0d ready", k), 64'(req_ready_o), 64'h1);
        end
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 8'h00);
        #1;
        chk("full mem_req", 64'(mem_req_o), 64'h0);
        chk("full ready", 64'(req_ready_o), 64'h0);
        // response while full: pop only, no push this cycle
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b1, 8'hC0);
        #1;
        chk("full+rv mem_req", 64'(mem_req_o), 64'h0);
        chk("full+rv rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("full+rv rdata", rsp_rdata_o, {8{8'hC0}});
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 8'h00);
        #1;
        chk("refill ready", 64'(req_ready_o), 64'h1);
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 8'h00);
        #1;
        chk("refull mem_req", 64'(mem_req_o), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(2'b00, 1'b0, 1'b1, 8'(8'hD0 + k));
            #1;
            chk($sformatf("drain%0d rsp_valid", k), 64'(rsp_valid_o), 64'h1);
            chk($sformatf("drain%0d rdata", k), rsp_rdata_o, {8{8'(8'hD0 + k)}});
        end

        // async reset with 3 outstanding
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(2'b01, 1'b1, 1'b0, 8'h00);
        end
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b1, 8'hEE);
        #1;
        chk("pre-rst rsp_valid", 64'(rsp_valid_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        chk("async rst mem_req", 64'(mem_req_o), 64'h0);
        chk("async rst ready", 64'(req_ready_o), 64'h0);
        chk("async rst rsp_valid", 64'(rsp_valid_o), 64'h0);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        drive(2'b10, 1'b1, 1'b0, 8'h00);
        #1;
        chk("post-rst ready", 64'(req_ready_o), 64'h2);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1, 8'h99);
        #1;
        chk("post-rst rsp_valid", 64'(rsp_valid_o), 64'h2);
        chk("post-rst rdata", rsp_rdata_o, {8{8'h99}});

`ifdef TB_MEM_ARB_PERF_EN
        // req0 stalled 7 cycles by withheld grant
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(2'b01, 1'b0, 1'b0, 8'h00);
        end
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 8'h00);
        #1;
        chk("perf stall0", 64'(perf_stall_o[31:0]), 64'd7);
        chk("perf stall1", 64'(perf_stall_o[63:32]), 64'd0);
        chk("perf ready", 64'(req_ready_o), 64'h1);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b1, 8'h5A);
        #1;
        chk("perf rsp_valid", 64'(rsp_valid_o), 64'h1);
`endif

        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
